instr_assemble_loader: RTL
==========================

# instr_assemble_loader

Streaming LEGv8 instruction assembler and loader: accepts decoded instruction fields over a valid/ready handshake, packs them into 32-bit R/D/I/B/CB machine words, and writes them sequentially into instruction memory. It is the encode-side counterpart of `instr_parse`. Every word it writes must re-parse through `instr_parse` to the same rm/rn/rd/address/opcode values. It sits between the test/boot stimulus and the instruction memory write port.

## Interface
- `ADDR_W`, 6: instruction-memory word-address width (capacity 2^ADDR_W words).
- `BASE_ADDR`, 0: first word address written after `start`.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high reset. One clock domain only.
- `start`  in  1: begin a new load; honoured only in IDLE or DONE.
- `in_valid`  in  1: field bundle valid.
- `in_ready`  out  1: block can accept a bundle.
- `in_last`  in  1: this bundle ends the program.
- `fmt`  in  3: 0=R, 1=D, 2=I, 3=B, 4=CB; 5-7 illegal.
- `opcode`  in  11: opcode in 11-bit `instr_parse` form, i.e. instruction[31:21].
- `rm_num`, `rn_num`, `rd_num`  in  5 each: register numbers; `rd_num` also carries Rt.
- `shamt`  in  6: R-format shift amount.
- `address`  in  9: D-format offset.
- `imm`  in  12: I-format immediate.
- `br_addr`  in  26: B-format offset; CB-format uses bits [18:0].
- `imem_we`  out  1: memory write strobe.
- `imem_addr`  out  ADDR_W: write word address.
- `imem_wdata`  out  32: encoded instruction.
- `count`  out  ADDR_W+1: words written since `start`.
- `busy`, `done`, `full`, `err_fmt`  out  1 each: status.

## Operation
- States:
  - IDLE: after reset.
  - LOAD: `start` from IDLE or DONE. Clears `count`, `full`, `err_fmt` and `done`; sets the write pointer to BASE_ADDR.
  - DONE: entered after `in_last` is accepted. `start` in DONE re-enters LOAD.
- `start` while in LOAD is ignored.
- `in_ready` = (state==LOAD) && !full. A transfer occurs when `in_valid && in_ready`.
- Encoding per format:
  - R: {opcode, rm, shamt, rn, rd}.
  - D: {opcode, address, 2'b00, rn, rd}.
  - I: {opcode[10:1], imm, rn, rd}.
  - B: {opcode[10:5], br_addr}.
  - CB: {opcode[10:3], br_addr[18:0], rd}.
- Unused input bits are ignored. No sign handling: fields are copied bit-exact.
- Illegal `fmt`: the bundle is accepted, nothing is written, the pointer is not advanced, and `err_fmt` is set and stays set until `start`. If `in_last` is set on that bundle, the block still goes to DONE.
- Each legal transfer writes one word and increments the pointer and `count`.
- `full` is set when `count` reaches 2^ADDR_W. `in_ready` then stays low and the state remains LOAD until `reset` (or `start` after DONE, which cannot occur without `in_last`). The bench must end programs with `in_last` before capacity is exceeded.
- Pointer wrap: BASE_ADDR + count is computed modulo 2^ADDR_W.

## Timing
- Reset values:
  - state IDLE.
  - `in_ready`, `imem_we`, `busy`, `done`, `full`, `err_fmt` = 0.
  - `imem_addr` = BASE_ADDR.
  - `imem_wdata` = 0.
  - `count` = 0.
- Write latency is 1 cycle: a transfer on edge N drives `imem_we`/`imem_addr`/`imem_wdata` for the cycle after edge N. `count` updates at edge N.
- Throughput is one word per cycle. Back-to-back transfers produce back-to-back writes.
- `done` is high from the edge after the final write until `start`. `busy` = state==LOAD or a write is pending.
- Simultaneous `in_last` on the transfer that fills memory: the block goes to DONE and `full` is also set.
- `reset` mid-load: immediate return to reset values, and any pending write is dropped (`imem_we` drops asynchronously).

## Structure
- `legv8_pkg`: `fmt_t` enum, field bit-position constants, and opcode constants (LDUR 0x7C2, STUR 0x7C0, ADD 0x458, ADDI 0x488, B 0x0A0, CBZ 0x5A0). Shared with `instr_parse`.
- Sub-module `instr_encode`: combinational fields→word plus an illegal-format flag.
- Top level: FSM, pointer/count, output register.

## Test plan
- LDUR X9,[X22,#240] (D, 0x7C2, rn 22, rd 9, addr 240) -> write 0xF84F02C9 at addr 0.
- Back-to-back ADD X10,X21,X9 (R, 0x458) then STUR X10,[X23,#64] (D, 0x7C0, `in_last`) -> 0x8B0902AA @0 and 0xF80402EA @1 on consecutive cycles; `done`=1, `count`=2.
- ADDI X1,X2,#5 (I, 0x488); B #3 (B, 0x0A0); CBZ X3,#8 (CB, 0x5A0, rd 3) -> 0x91001441, 0x14000003, 0xB4000103. Each word fed through `instr_parse` returns the original fields.
- `fmt`=6 mid-stream -> no write, `count` unchanged, `err_fmt`=1; the next legal word lands at the next address.
- ADDR_W=2: four words without `in_last` -> `full`=1, `in_ready`=0; a fifth `in_valid` is held off.
- Assert `reset` while `in_valid` is held -> all outputs return to reset values in the same cycle; `start` then restarts at BASE_ADDR.

Source files
------------

// File: rtl/instr_assemble_loader_pkg.sv
// instr_assemble_loader_pkg: LEGv8 format codes, loader states and opcode constants.
package instr_assemble_loader_pkg;
    typedef enum logic [2:0] {FMT_R, FMT_D, FMT_I, FMT_B, FMT_CB} fmt_t;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;
    localparam logic [10:0] OPC_LDUR = 11'h7C2;
    localparam logic [10:0] OPC_STUR = 11'h7C0;
    localparam logic [10:0] OPC_ADD  = 11'h458;
    localparam logic [10:0] OPC_ADDI = 11'h488;
    localparam logic [10:0] OPC_B    = 11'h0A0;
    localparam logic [10:0] OPC_CBZ  = 11'h5A0;
    function automatic logic fmt_legal(logic [2:0] f);
        return f <= FMT_CB;
    endfunction
endpackage

// File: rtl/instr_assemble_loader_if.sv
// instr_assemble_loader_if: field-bundle handshake, imem write port and loader status.
interface instr_assemble_loader_if #(parameter int ADDR_W = 6);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [2:0]        fmt;
    logic [10:0]       opcode;
    logic [4:0]        rm_num;
    logic [4:0]        rn_num;
    logic [4:0]        rd_num;
    logic [5:0]        shamt;
    logic [8:0]        address;
    logic [11:0]       imm;
    logic [25:0]       br_addr;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              done;
    logic              full;
    logic              err_fmt;
    modport master (
        output start, in_valid, in_last, fmt, opcode, rm_num, rn_num, rd_num, shamt, address, imm, br_addr,
        input  in_ready, imem_we, imem_addr, imem_wdata, count, busy, done, full, err_fmt
    );
    modport slave (
        input  start, in_valid, in_last, fmt, opcode, rm_num, rn_num, rd_num, shamt, address, imm, br_addr,
        output in_ready, imem_we, imem_addr, imem_wdata, count, busy, done, full, err_fmt
    );
endinterface

// File: rtl/instr_assemble_loader_encode.sv
// instr_assemble_loader_encode: packs decoded fields into an R/D/I/B/CB machine word.
module instr_assemble_loader_encode
    import instr_assemble_loader_pkg::*;
(
    input  logic [2:0]  fmt_i,
    input  logic [10:0] opcode_i,
    input  logic [4:0]  rm_i,
    input  logic [4:0]  rn_i,
    input  logic [4:0]  rd_i,
    input  logic [5:0]  shamt_i,
    input  logic [8:0]  address_i,
    input  logic [11:0] imm_i,
    input  logic [25:0] br_addr_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);
    always_comb begin
        illegal_o = !fmt_legal(fmt_i);
        word_o = fmt_i == FMT_R  ? {opcode_i, rm_i, shamt_i, rn_i, rd_i} :
                 fmt_i == FMT_D  ? {opcode_i, address_i, 2'b00, rn_i, rd_i} :
                 fmt_i == FMT_I  ? {opcode_i[10:1], imm_i, rn_i, rd_i} :
                 fmt_i == FMT_B  ? {opcode_i[10:5], br_addr_i} :
                 fmt_i == FMT_CB ? {opcode_i[10:3], br_addr_i[18:0], rd_i} : '0;
    end
endmodule

// File: rtl/instr_assemble_loader.sv
// instr_assemble_loader: streams encoded LEGv8 words into instruction memory, one per cycle.
// Load FSM plus a registered write port; the write pointer is BASE_ADDR + count, wrapping.
module instr_assemble_loader
    import instr_assemble_loader_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input logic                   clk,
    input logic                   reset,
    instr_assemble_loader_if.slave bus
);
    state_t            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d, word;
    logic              full_q, full_d, err_q, err_d, we_q, we_d;
    logic              illegal, xfer, go;

    instr_assemble_loader_encode u_encode (
        .fmt_i(bus.fmt), .opcode_i(bus.opcode), .rm_i(bus.rm_num), .rn_i(bus.rn_num),
        .rd_i(bus.rd_num), .shamt_i(bus.shamt), .address_i(bus.address), .imm_i(bus.imm),
        .br_addr_i(bus.br_addr), .word_o(word), .illegal_o(illegal)
    );

    assign go   = bus.start && state_q != S_LOAD;
    assign xfer = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = go ? S_LOAD : (xfer && bus.in_last) ? S_DONE : state_q;
    end

    always_comb begin
        bus.in_ready = state_q == S_LOAD && !full_q;
        bus.busy     = state_q == S_LOAD || we_q;
        bus.done     = state_q == S_DONE && !we_q;
    end

    // Illegal bundles are consumed but only flag an error; they never occupy a slot.
    always_comb begin
        we_d    = xfer && !illegal;
        count_d = go ? '0 : count_q + (ADDR_W+1)'(we_d);
        full_d  = !go && (full_q || count_d[ADDR_W]);
        err_d   = !go && (err_q || (xfer && illegal));
        addr_d  = we_d ? ADDR_W'(BASE_ADDR) + count_q[ADDR_W-1:0] : addr_q;
        wdata_d = we_d ? word : wdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            addr_q  <= ADDR_W'(BASE_ADDR);
            wdata_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            full_q  <= full_d;
            err_q   <= err_d;
            we_q    <= we_d;
        end
    end

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.count      = count_q;
    assign bus.full       = full_q;
    assign bus.err_fmt    = err_q;
endmodule
